// File: rtl/ro_puf_sequencer.sv
// Ring-oscillator PUF challenge/response sequencer: for every response bit it selects
// LUT stages, lets both rings settle, counts their synchronized edges and compares them.
module ro_puf_sequencer #(
    parameter int N_STAGES  = 5,
    parameter int RESP_BITS = 8,
    parameter int SETTLE    = 16,
    parameter int WINDOW    = 1024,
    parameter int CNT_W     = 16
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          START,
    input  logic [RESP_BITS*N_STAGES-1:0] CHALLENGE,
    input  logic                          RO_A,
    input  logic                          RO_B,
    output logic [N_STAGES-1:0]           RO_SEL,
    output logic                          RO_EN,
    output logic                          BUSY,
    output logic                          DONE,
    output logic [RESP_BITS-1:0]          RESPONSE,
    output logic                          SAT
);
    localparam int DRAIN_CYCLES = 3;
    localparam int T_MAX0       = (SETTLE > WINDOW) ? SETTLE : WINDOW;
    localparam int T_MAX        = (T_MAX0 > DRAIN_CYCLES) ? T_MAX0 : DRAIN_CYCLES;
    localparam int TW           = $clog2(T_MAX + 1);
    localparam int IW           = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_MEASURE,
        ST_DRAIN,
        ST_COMPARE
    } state_t;

    state_t                        state;
    state_t                        state_next;
    logic [TW-1:0]                 timer;
    logic [TW-1:0]                 timer_load_val;
    logic                          timer_load;
    logic [IW-1:0]                 index;
    logic [RESP_BITS*N_STAGES-1:0] challenge_q;
    logic [2:0]                    sync_a;
    logic [2:0]                    sync_b;
    logic [CNT_W-1:0]              cnt_a;
    logic [CNT_W-1:0]              cnt_b;
    logic                          rise_a;
    logic                          rise_b;
    logic                          counting;
    logic                          last_bit;
    logic                          done_q;
    logic                          sat_q;
    logic [RESP_BITS-1:0]          response_q;
    logic [N_STAGES-1:0]           sel_q;

    // Bits [1:0] form the synchronizer; bit 2 is the previous value for edge detection.
    assign rise_a   = sync_a[1] & ~sync_a[2];
    assign rise_b   = sync_b[1] & ~sync_b[2];
    assign counting = (state == ST_MEASURE) || (state == ST_DRAIN);
    assign last_bit = (index == IW'(RESP_BITS - 1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
            timer <= '0;
        end else begin
            state <= state_next;
            if (timer_load) begin
                timer <= timer_load_val;
            end else if (timer != '0) begin
                timer <= timer - TW'(1);
            end
        end
    end

    always_comb begin
        state_next     = state;
        timer_load     = 1'b0;
        timer_load_val = '0;
        case (state)
            ST_IDLE: begin
                if (START) begin
                    state_next     = ST_SETTLE;
                    timer_load     = 1'b1;
                    timer_load_val = TW'(SETTLE - 1);
                end
            end
            ST_SETTLE: begin
                if (timer == '0) begin
                    state_next     = ST_MEASURE;
                    timer_load     = 1'b1;
                    timer_load_val = TW'(WINDOW - 1);
                end
            end
            ST_MEASURE: begin
                if (timer == '0) begin
                    state_next     = ST_DRAIN;
                    timer_load     = 1'b1;
                    timer_load_val = TW'(DRAIN_CYCLES - 1);
                end
            end
            ST_DRAIN: begin
                if (timer == '0) begin
                    state_next = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                if (last_bit) begin
                    state_next = ST_IDLE;
                end else begin
                    state_next     = ST_SETTLE;
                    timer_load     = 1'b1;
                    timer_load_val = TW'(SETTLE - 1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Counters are cleared outside MEASURE/DRAIN, so COMPARE reads the final counts.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_a      <= '0;
            sync_b      <= '0;
            cnt_a       <= '0;
            cnt_b       <= '0;
            index       <= '0;
            challenge_q <= '0;
            response_q  <= '0;
            sat_q       <= 1'b0;
            done_q      <= 1'b0;
            sel_q       <= '0;
        end else begin
            sync_a <= {sync_a[1:0], RO_A};
            sync_b <= {sync_b[1:0], RO_B};
            done_q <= 1'b0;

            if (counting) begin
                if (rise_a && (cnt_a != '1)) begin
                    cnt_a <= cnt_a + CNT_W'(1);
                end
                if (rise_b && (cnt_b != '1)) begin
                    cnt_b <= cnt_b + CNT_W'(1);
                end
            end else begin
                cnt_a <= '0;
                cnt_b <= '0;
            end

            case (state)
                ST_IDLE: begin
                    if (START) begin
                        challenge_q <= CHALLENGE;
                        response_q  <= '0;
                        sat_q       <= 1'b0;
                        index       <= '0;
                        sel_q       <= CHALLENGE[N_STAGES-1:0];
                    end
                end
                ST_COMPARE: begin
                    response_q[index] <= (cnt_a > cnt_b);
                    sat_q             <= sat_q | (cnt_a == '1) | (cnt_b == '1);
                    if (last_bit) begin
                        done_q <= 1'b1;
                    end else begin
                        index <= index + IW'(1);
                        sel_q <= challenge_q[(int'(index) + 1) * N_STAGES +: N_STAGES];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign RO_SEL   = sel_q;
    assign RO_EN    = (state == ST_MEASURE);
    assign BUSY     = (state != ST_IDLE);
    assign DONE     = done_q;
    assign RESPONSE = response_q;
    assign SAT      = sat_q;

endmodule

// File: tb/tb_ro_puf_sequencer.sv
// Self-checking bench for ro_puf_sequencer: a schedule/sample-history model predicts
// every output each cycle, plus hand-computed expectations for the directed scenarios.
module tb_ro_puf_sequencer;
    localparam int NS   = 5;
    localparam int RB   = 4;
    localparam int ST   = 4;
    localparam int WIN  = 100;
    localparam int CW   = 5;
    localparam int P    = ST + WIN + 4;
    localparam int RUN  = RB * P;
    localparam int CMAX = (1 << CW) - 1;
    localparam int HMAX = 20000;
    localparam int CHW  = RB * NS;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic           ro_a = 1'b0;
    logic           ro_b = 1'b0;
    logic [CHW-1:0] challenge = '0;
    logic [NS-1:0]  ro_sel;
    logic           ro_en;
    logic           busy;
    logic           done;
    logic [RB-1:0]  response;
    logic           sat;

    ro_puf_sequencer #(
        .N_STAGES (NS),
        .RESP_BITS(RB),
        .SETTLE   (ST),
        .WINDOW   (WIN),
        .CNT_W    (CW)
    ) dut (
        .CLK      (clk),
        .RST      (rst),
        .START    (start),
        .CHALLENGE(challenge),
        .RO_A     (ro_a),
        .RO_B     (ro_b),
        .RO_SEL   (ro_sel),
        .RO_EN    (ro_en),
        .BUSY     (busy),
        .DONE     (done),
        .RESPONSE (response),
        .SAT      (sat)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit hist_a [HMAX];
    bit hist_b [HMAX];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Square-wave rings changing on the falling edge; in select mode A is fast only when RO_SEL[0]=1.
    int per_a = 8;
    int per_b = 10;
    bit sel_dep = 1'b0;
    int ta = 0;
    int tb = 0;
    int pa_now;
    always @(negedge clk) begin
        pa_now = sel_dep ? ((ro_sel[0] === 1'b1) ? 4 : 12) : per_a;
        ta     = (ta + 1) % pa_now;
        tb     = (tb + 1) % per_b;
        ro_a   = (ta < pa_now / 2);
        ro_b   = (tb < per_b / 2);
    end

    bit             run_live = 1'b0;
    int             e0 = -1000000;
    logic [CHW-1:0] chal_m = '0;
    logic [RB-1:0]  resp_m = '0;
    bit             sat_m = 1'b0;
    logic [NS-1:0]  sel_m = '0;

    // Rising edges seen by the sampled ring whose detection lands in the counting cycles of a bit.
    function automatic int count_edges(input bit use_b, input int base);
        int c = 0;
        for (int k = base + ST + 1; k <= base + ST + WIN + 3; k++) begin
            bit cur;
            bit prev;
            cur  = use_b ? hist_b[k-2] : hist_a[k-2];
            prev = use_b ? hist_b[k-3] : hist_a[k-3];
            if (cur && !prev) c++;
        end
        return c;
    endfunction

    always @(posedge clk) begin
        int o;
        int bi;
        int ca;
        int cb;
        if (cyc < HMAX) begin
            hist_a[cyc] = ro_a;
            hist_b[cyc] = ro_b;
        end
        if (rst) begin
            run_live = 1'b0;
            resp_m   = '0;
            sat_m    = 1'b0;
            sel_m    = '0;
        end else begin
            o = cyc - e0;
            if (run_live && o > 0 && o <= RUN && (o % P) == 0) begin
                bi = o / P - 1;
                ca = count_edges(1'b0, e0 + bi * P);
                cb = count_edges(1'b1, e0 + bi * P);
                if (ca >= CMAX || cb >= CMAX) sat_m = 1'b1;
                if (ca > CMAX) ca = CMAX;
                if (cb > CMAX) cb = CMAX;
                resp_m[bi] = (ca > cb);
            end
            if (start && (!run_live || o > RUN)) begin
                e0       = cyc;
                run_live = 1'b1;
                chal_m   = challenge;
                resp_m   = '0;
                sat_m    = 1'b0;
            end
        end
        cyc++;
    end

    bit            exp_busy;
    bit            exp_en;
    bit            exp_done;
    logic [NS-1:0] exp_sel;
    int            ko;
    always @(posedge clk) begin
        #1;
        ko       = (cyc - 1) - e0;
        exp_busy = run_live && (ko < RUN);
        exp_en   = exp_busy && ((ko % P) >= ST) && ((ko % P) < ST + WIN);
        exp_done = run_live && (ko == RUN);
        if (exp_busy) begin
            exp_sel = chal_m[(ko / P) * NS +: NS];
            sel_m   = exp_sel;
        end else begin
            exp_sel = sel_m;
        end
        check_output("busy", 32'(busy), 32'(exp_busy));
        check_output("ro_en", 32'(ro_en), 32'(exp_en));
        check_output("done", 32'(done), 32'(exp_done));
        check_output("ro_sel", 32'(ro_sel), 32'(exp_sel));
        check_output("response", 32'(response), 32'(resp_m));
        check_output("sat", 32'(sat), 32'(sat_m));
    end

    logic [NS-1:0] sel_seen [$];
    logic          en_prev = 1'b0;
    always @(posedge clk) begin
        #1;
        if (ro_en === 1'b1 && en_prev !== 1'b1) sel_seen.push_back(ro_sel);
        en_prev = ro_en;
    end

    task automatic set_osc(input int pa, input int pb, input int pha, input int phb, input bit dep);
        @(posedge clk);
        #2;
        per_a   = pa;
        per_b   = pb;
        sel_dep = dep;
        ta      = pha;
        tb      = phb;
    endtask

    task automatic apply_stimulus(input logic [CHW-1:0] chal);
        @(negedge clk);
        challenge = chal;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        bit seen = 1'b0;
        lat = -1;
        for (int i = 0; i < RUN + 20 && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                lat  = (cyc - 1) - e0;
            end
        end
        check_output("done_seen", 32'(seen), 1);
    endtask

    logic [NS-1:0] exp_seq [4] = '{5'h1E, 5'h06, 5'h0F, 5'h15};

    initial begin
        int             lat;
        int             dcount;
        int             pa;
        int             pb;
        logic [CHW-1:0] rc;

        repeat (3) @(negedge clk);
        check_output("reset_busy", 32'(busy), 0);
        check_output("reset_response", 32'(response), 0);
        check_output("reset_ro_en", 32'(ro_en), 0);
        rst = 1'b0;

        set_osc(8, 10, 0, 0, 1'b0);
        apply_stimulus(20'h12345);
        wait_done(lat);
        check_output("basic_latency", lat, 432);
        check_output("basic_response", 32'(response), 'hF);
        check_output("basic_sat", 32'(sat), 0);

        set_osc(10, 8, 0, 0, 1'b0);
        apply_stimulus(20'h54321);
        wait_done(lat);
        check_output("swap_response", 32'(response), 'h0);

        // Select sequencing, with an ignored START carrying another challenge mid-run.
        sel_seen.delete();
        set_osc(8, 8, 0, 0, 1'b1);
        apply_stimulus(20'hABCDE);
        repeat (150) @(negedge clk);
        challenge = 20'h00000;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        check_output("sel_response", 32'(response), 'hC);
        check_output("sel_count", sel_seen.size(), 4);
        for (int i = 0; i < 4 && i < sel_seen.size(); i++) begin
            check_output("sel_slice", 32'(sel_seen[i]), 32'(exp_seq[i]));
        end

        // Tie, then START held on the DONE cycle.
        set_osc(8, 8, 0, 0, 1'b0);
        apply_stimulus(20'h0F0F0);
        wait_done(lat);
        check_output("tie_response", 32'(response), 'h0);
        challenge = 20'h13579;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_output("b2b_busy", 32'(busy), 1);
        wait_done(lat);
        check_output("b2b_response", 32'(response), 'h0);

        set_osc(2, 3, 0, 0, 1'b0);
        apply_stimulus(20'hFFFFF);
        wait_done(lat);
        check_output("sat_flag", 32'(sat), 1);
        check_output("sat_response", 32'(response), 'h0);

        // Reset in the middle of bit 3's measurement window.
        set_osc(8, 10, 0, 0, 1'b0);
        apply_stimulus(20'h2468A);
        repeat (3 * P + ST + 20) @(negedge clk);
        check_output("pre_abort_en", 32'(ro_en), 1);
        rst = 1'b1;
        @(negedge clk);
        check_output("abort_ro_en", 32'(ro_en), 0);
        check_output("abort_busy", 32'(busy), 0);
        check_output("abort_response", 32'(response), 0);
        @(negedge clk);
        rst    = 1'b0;
        dcount = 0;
        for (int i = 0; i < RUN + 20; i++) begin
            @(negedge clk);
            if (done === 1'b1) dcount++;
        end
        check_output("abort_no_done", dcount, 0);
        apply_stimulus(20'h2468A);
        wait_done(lat);
        check_output("post_abort_response", 32'(response), 'hF);
        check_output("post_abort_latency", lat, 432);

        for (int r = 0; r < 6; r++) begin
            pa = $urandom_range(2, 16);
            pb = $urandom_range(2, 16);
            set_osc(pa, pb, $urandom_range(0, pa - 1), $urandom_range(0, pb - 1), 1'b0);
            rc = CHW'($urandom());
            apply_stimulus(rc);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(10, 300)) @(negedge clk);
                challenge = CHW'($urandom());
                start     = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            wait_done(lat);
            check_output("rand_latency", lat, 432);
        end

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ro_puf_sequencer.md
Name: ro_puf_sequencer

Overview:
Challenge/response controller for the ring-oscillator PUF built from inverting LUT stages. For each response bit it performs four steps:
- applies a per-bit stage-select word to both oscillators,
- lets them settle,
- counts synchronized edges of oscillator A and oscillator B over a fixed window,
- writes one response bit from the comparison.
It sits between the host/encryption logic (START/CHALLENGE/RESPONSE) and the oscillator array (RO_SEL/RO_EN/RO_A/RO_B).

Parameters:
N_STAGES, 5, select bits per oscillator (one per inverting LUT stage)
RESP_BITS, 8, response bits generated per challenge
SETTLE, 16, clocks RO_EN is held low with new RO_SEL before measuring (>=1)
WINDOW, 1024, clocks RO_EN is high per measurement (>=1)
CNT_W, 16, edge counter width

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  synchronous, active-high reset
START  input  1  request; sampled only in IDLE
CHALLENGE  input  RESP_BITS*N_STAGES  challenge; slice i = CHALLENGE[i*N_STAGES +: N_STAGES] configures bit i
RO_A  input  1  asynchronous output of oscillator A
RO_B  input  1  asynchronous output of oscillator B
RO_SEL  output  N_STAGES  stage selects driven to both oscillators
RO_EN  output  1  oscillator enable
BUSY  output  1  high whenever state != IDLE
DONE  output  1  one-cycle pulse: RESPONSE valid
RESPONSE  output  RESP_BITS  response word, held until next accepted START
SAT  output  1  some counter saturated during the last challenge; valid with DONE, held

Behaviour:
- Reset (synchronous, any state, including mid-measurement):
  - state=IDLE; bit index=0; counters=0; synchronizer flops=0.
  - RO_EN=0, RO_SEL=0, BUSY=0, DONE=0, RESPONSE=0, SAT=0.
- Synchronizers: RO_A and RO_B each pass through a 2-flop synchronizer, then a rising-edge detector (third flop). A counter increments only on a detected rising edge. Oscillator frequency must be below CLK/2; faster rings alias and are not detected.
- Counters: CNT_W bits, saturate at all-ones. Hitting saturation sets the SAT sticky bit for the current challenge.
- IDLE:
  - START=1 latches CHALLENGE, clears RESPONSE, SAT and the bit index, and moves to SETTLE.
  - START in any other state is ignored; CHALLENGE changes after acceptance have no effect.
- SETTLE (SETTLE clocks):
  - RO_SEL = latched slice[index]; RO_EN=0; both counters held at 0.
- MEASURE (WINDOW clocks): RO_EN=1, RO_SEL held, counters count.
- DRAIN (3 clocks): RO_EN=0; counting continues so in-flight synchronized edges land.
- COMPARE (1 clock):
  - RESPONSE[index] = (cntA > cntB). A tie gives 0.
  - If index == RESP_BITS-1, go to IDLE. Otherwise increment index and go to SETTLE.
- DONE:
  - Pulses high for exactly the first IDLE cycle after the final COMPARE.
  - RESPONSE and SAT are final in that cycle.
  - DONE is never asserted after a reset-aborted run.
- Latency: if START is accepted at edge e0, DONE is high in the cycle after edge e0 + RESP_BITS*(SETTLE+WINDOW+4).
- RO_SEL keeps its last value in IDLE.
- BUSY falls in the same cycle DONE rises.
- A back-to-back START in the DONE cycle is accepted.

Test Plan:
- Reset/idle: assert RST for 2 clocks mid-MEASURE of bit 3 → next cycle RO_EN=0, BUSY=0, RESPONSE=0. No DONE follows. A subsequent START runs a full 8-bit challenge normally.
- Basic compare: SETTLE=4, WINDOW=64, RESP_BITS=2; RO_A period 8 clk, RO_B period 10 clk for both bits → RESPONSE=2'b11, SAT=0, DONE exactly 1+2*(4+64+4) edges after START is sampled. Swap the periods → RESPONSE=2'b00.
- Sequencing/select: RESP_BITS=4, N_STAGES=5, CHALLENGE=20'hABCDE. Bench model makes A faster only when RO_SEL[0]=1 → RO_SEL slices observed in MEASURE are 0x1E,0x06,0x0F,0x15 in order, and RESPONSE=4'b1100 (bit0 first).
- Tie: identical 8-clk waveforms on A and B, phase-aligned, WINDOW=64 → counts equal (8), RESPONSE bits all 0.
- Saturation: CNT_W=4, WINDOW=256, A period 4 clk, B period 6 clk → both counters stop at 15, SAT=1 with DONE, bit=0.
- START handling: pulse START during BUSY with a different CHALLENGE → ignored, RESPONSE matches the first challenge. START held high on the DONE cycle → new run begins next cycle with BUSY=1.
